// File: rtl/pc_ctrl_pkg.sv
// Shared constants and state encodings for the instruction-fetch program counter.
package pc_ctrl_pkg;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic RstEnable   = 1'b1;

  localparam int unsigned InstAddrBus = 32;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_ctrl_next_mux.sv
// Combinational next-pc priority select: flush > stall > pending/branch > increment.
// Targets arrive already aligned.
module pc_ctrl_next_mux #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INST_BYTES = 4
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_al,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_al,
  input  logic              pend_valid,
  input  logic [ADDR_W-1:0] pend_target,
  output logic [ADDR_W-1:0] pc_nxt,
  output logic              pend_valid_nxt,
  output logic [ADDR_W-1:0] pend_target_nxt
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(INST_BYTES);

  always_comb begin
    pc_nxt          = pc + INC;
    pend_valid_nxt  = pend_valid;
    pend_target_nxt = pend_target;
    if (flush) begin
      pc_nxt         = flush_al;
      pend_valid_nxt = 1'b0;
    end else if (stall) begin
      pc_nxt = pc;
      // A newer branch during the same stall replaces the held one.
      if (branch_flag) begin
        pend_target_nxt = branch_al;
        pend_valid_nxt  = 1'b1;
      end
    end else if (pend_valid) begin
      pend_valid_nxt = 1'b0;
      pc_nxt         = branch_flag ? branch_al : pend_target;
    end else if (branch_flag) begin
      pc_nxt = branch_al;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter unit for instruction fetch: boot hold, stall, branch redirect
// with deferral across stalls, and exception/flush redirect.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = InstAddrBus,
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned INST_BYTES   = 4,
  parameter int unsigned ALIGN_LSB    = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              pend_valid
);

  localparam logic [ADDR_W-1:0] RST_PC     = ADDR_W'(RESET_VECTOR);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << ALIGN_LSB;

  pc_state_e         state, state_nxt;
  logic [ADDR_W-1:0] pend_target;
  logic [ADDR_W-1:0] pc_nxt, pend_target_nxt;
  logic              pend_valid_nxt;
  logic [ADDR_W-1:0] branch_al, flush_al;

  assign branch_al = branch_target & ALIGN_MASK;
  assign flush_al  = flush_pc & ALIGN_MASK;

  always_ff @(posedge Clk) begin
    if (Rst == RstEnable) state <= BOOT;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ce        = ChipDisable;
    if (state == BOOT) begin
      state_nxt = RUN;
    end else begin
      ce = ChipEnable;
    end
  end

  pc_ctrl_next_mux #(
    .ADDR_W     (ADDR_W),
    .INST_BYTES (INST_BYTES)
  ) u_next_mux (
    .pc              (pc),
    .stall           (stall),
    .branch_flag     (branch_flag),
    .branch_al       (branch_al),
    .flush           (flush),
    .flush_al        (flush_al),
    .pend_valid      (pend_valid),
    .pend_target     (pend_target),
    .pc_nxt          (pc_nxt),
    .pend_valid_nxt  (pend_valid_nxt),
    .pend_target_nxt (pend_target_nxt)
  );

  // BOOT->RUN edge keeps the reset vector so it is fetched once with ce high.
  always_ff @(posedge Clk) begin
    if (Rst == RstEnable || state == BOOT) begin
      pc         <= RST_PC;
      pend_valid <= 1'b0;
    end else begin
      pc         <= pc_nxt;
      pend_valid <= pend_valid_nxt;
    end
  end

  // Held target is only read while pend_valid is set, so it needs no reset.
  always_ff @(posedge Clk) begin
    pend_target <= pend_target_nxt;
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_ctrl;

  localparam int unsigned ADDR_W = 32;

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic              stall = 1'b0;
  logic              branch_flag = 1'b0;
  logic [ADDR_W-1:0] branch_target = '0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] flush_pc = '0;
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic              pend_valid;

  int checks = 0;
  int errors = 0;

  // Behavioural reference state
  bit          m_run = 1'b0;
  logic [31:0] m_pc = 32'h0;
  bit          m_pv = 1'b0;
  logic [31:0] m_pt = 32'h0;

  pc_ctrl #(
    .ADDR_W       (ADDR_W),
    .RESET_VECTOR (32'h0000_0000),
    .INST_BYTES   (4),
    .ALIGN_LSB    (2)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .stall         (stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .pc            (pc),
    .ce            (ce),
    .pend_valid    (pend_valid)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    if (Rst) begin
      m_run = 1'b0; m_pc = 32'h0; m_pv = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1; m_pc = 32'h0; m_pv = 1'b0;
    end else if (flush) begin
      m_pc = {flush_pc[31:2], 2'b00}; m_pv = 1'b0;
    end else if (stall) begin
      if (branch_flag) begin m_pv = 1'b1; m_pt = {branch_target[31:2], 2'b00}; end
    end else if (m_pv) begin
      m_pc = branch_flag ? {branch_target[31:2], 2'b00} : m_pt;
      m_pv = 1'b0;
    end else if (branch_flag) begin
      m_pc = {branch_target[31:2], 2'b00};
    end else begin
      m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  task automatic idle();
    Rst = 1'b0; stall = 1'b0; branch_flag = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
    Rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ce !== 1'b0 || pc !== 32'h0 || pend_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: ce=%b pc=%h pv=%b, want ce=0 pc=0 pv=0", i, ce, pc, pend_valid);
      end
    end
    Rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ce !== 1'b1 || pc !== exp_pc[i]) begin
        errors++;
        $display("FAIL reset_release cyc%0d: ce=%b pc=%h, want ce=1 pc=%h", i, ce, pc, exp_pc[i]);
      end
    end
  endtask

  task automatic test_stall();
    idle(); branch_flag = 1'b1; branch_target = 32'h10;
    step();
    branch_flag = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) stall = 1'b0;
      step();
      checks++;
      if (pc !== ((i == 2) ? 32'h14 : 32'h10)) begin
        errors++;
        $display("FAIL stall_hold cyc%0d: pc=%h want %h", i, pc, (i == 2) ? 32'h14 : 32'h10);
      end
    end
  endtask

  task automatic test_branch_under_stall();
    logic [31:0] held;
    idle(); held = pc;
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h100;
    step();
    branch_flag = 1'b0;
    checks++;
    if (pc !== held || pend_valid !== 1'b1) begin
      errors++;
      $display("FAIL defer_capture: pc=%h pv=%b, want pc=%h pv=1", pc, pend_valid, held);
    end
    stall = 1'b0;
    step();
    checks++;
    if (pc !== 32'h100 || pend_valid !== 1'b0) begin
      errors++;
      $display("FAIL defer_apply: pc=%h pv=%b, want pc=100 pv=0", pc, pend_valid);
    end
    step();
    checks++;
    if (pc !== 32'h104) begin
      errors++;
      $display("FAIL defer_after: pc=%h want 104", pc);
    end
  endtask

  task automatic test_back_to_back();
    idle(); stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h400;
    step();
    branch_target = 32'h500;
    step();
    branch_flag = 1'b0; stall = 1'b0;
    step();
    checks++;
    if (pc !== 32'h500) begin
      errors++;
      $display("FAIL last_branch_wins: pc=%h want 500", pc);
    end
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h600;
    step();
    stall = 1'b0; branch_target = 32'h700;
    step();
    branch_flag = 1'b0;
    checks++;
    if (pc !== 32'h700 || pend_valid !== 1'b0) begin
      errors++;
      $display("FAIL live_branch_over_pend: pc=%h pv=%b, want pc=700 pv=0", pc, pend_valid);
    end
  endtask

  task automatic test_flush_priority();
    idle(); stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h240;
    step();
    flush = 1'b1; flush_pc = 32'h180; branch_target = 32'h200;
    step();
    checks++;
    if (pc !== 32'h180 || pend_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_priority: pc=%h pv=%b, want pc=180 pv=0", pc, pend_valid);
    end
    idle();
    step();
    checks++;
    if (pc !== 32'h184) begin
      errors++;
      $display("FAIL flush_drops_pend: pc=%h want 184", pc);
    end
  endtask

  task automatic test_wrap_align();
    idle(); flush = 1'b1; flush_pc = 32'hFFFF_FFFE;
    step();
    flush = 1'b0;
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL flush_align: pc=%h want fffffffc", pc);
    end
    step();
    checks++;
    if (pc !== 32'h0) begin
      errors++;
      $display("FAIL wrap: pc=%h want 00000000", pc);
    end
    branch_flag = 1'b1; branch_target = 32'h1003;
    step();
    branch_flag = 1'b0;
    checks++;
    if (pc !== 32'h1000) begin
      errors++;
      $display("FAIL branch_align: pc=%h want 1000", pc);
    end
  endtask

  task automatic test_reset_mid();
    idle(); stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h300;
    step();
    branch_flag = 1'b0; Rst = 1'b1;
    step();
    checks++;
    if (pc !== 32'h0 || ce !== 1'b0 || pend_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: pc=%h ce=%b pv=%b, want pc=0 ce=0 pv=0", pc, ce, pend_valid);
    end
    idle();
    step();
    checks++;
    if (pc !== 32'h0 || ce !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_release: pc=%h ce=%b, want pc=0 ce=1", pc, ce);
    end
    step();
    checks++;
    if (pc !== 32'h4 || pend_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_redirect: pc=%h pv=%b, want pc=4 pv=0", pc, pend_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Rst           = ($urandom_range(0, 59) == 0);
      stall         = ($urandom_range(0, 2) == 0);
      branch_flag   = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      branch_target = $urandom();
      flush_pc      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | ($urandom() & 32'hF) : $urandom();
      step();
      checks++;
      if (pc !== m_pc || ce !== m_run || pend_valid !== m_pv) begin
        errors++;
        $display("FAIL random cyc%0d: pc=%h ce=%b pv=%b, want pc=%h ce=%b pv=%b",
                 i, pc, ce, pend_valid, m_pc, m_run, m_pv);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch_under_stall();
    test_back_to_back();
    test_flush_priority();
    test_wrap_align();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Parametrised program-counter unit for the instruction-fetch stage, the successor to the plain free-running PC register. It generates the fetch address and the instruction-memory chip enable. On top of sequential increment it adds pipeline stall hold, branch/jump redirect, and exception/flush redirect. A branch that arrives during a stall is captured and applied when the stall releases. Sits between the control/stall unit, the ID-stage branch resolver and instruction ROM/I-cache.

Parameters:
ADDR_W, 32, width of pc, branch target and flush target
RESET_VECTOR, 32'h00000000, pc value during reset and boot; truncated to ADDR_W
INST_BYTES, 4, increment per sequential fetch; power of two, 1..8
ALIGN_LSB, 2, log2(INST_BYTES); target bits [ALIGN_LSB-1:0] are forced to 0

Ports:
Clk  in  1  clock, all state updates on rising edge
Rst  in  1  synchronous reset, active-high
stall  in  1  hold pc (IF stall from the control unit)
branch_flag  in  1  one-cycle pulse: redirect to branch_target
branch_target  in  ADDR_W  branch/jump destination
flush  in  1  one-cycle pulse: exception/eret redirect to flush_pc
flush_pc  in  ADDR_W  exception handler or return address
pc  out  ADDR_W  current fetch address
ce  out  1  instruction-memory chip enable
pend_valid  out  1  a deferred branch is held (debug/verification visibility)

Behaviour:
- Reset and clock: Rst is synchronous, active-high; clock is Clk. Reset has top priority over all inputs.
- Reset values: ce=0, pc=RESET_VECTOR, pend_valid=0, state=BOOT.
- State machine:
  - BOOT: ce=0, pc holds RESET_VECTOR, all other inputs ignored. Goes to RUN on the first edge with Rst=0; ce becomes 1 on that edge.
  - RUN: ce=1.
  - Rst in any state returns to BOOT on the next edge.
- First fetch: pc stays RESET_VECTOR on the BOOT->RUN edge, so RESET_VECTOR is presented with ce=1 for at least one cycle. The first increment happens on the following edge.
- Priority per edge in RUN: flush > stall > pending/branch > increment.
  - flush=1: pc <= flush_pc (aligned), pend_valid <= 0. This applies even when stall=1 and overrides a simultaneous branch_flag.
  - else stall=1: pc holds. If branch_flag=1, latch pend_target <= branch_target (aligned) and set pend_valid <= 1. A newer branch while pend_valid=1 overwrites the latched target (last wins).
  - else pend_valid=1: pc <= pend_target, pend_valid <= 0. A same-cycle branch_flag takes precedence: pc <= branch_target, pend cleared.
  - else branch_flag=1: pc <= branch_target (aligned).
  - else: pc <= pc + INST_BYTES.
- Latency: every redirect is visible on pc one edge after the qualifying cycle. A deferred branch is visible one edge after the first cycle with stall=0.
- Arithmetic:
  - Increment is modulo 2^ADDR_W, so pc at the all-ones aligned address wraps to 0 with no flag.
  - Targets have their low ALIGN_LSB bits cleared before being loaded.
- Outside RUN: branch_flag and flush are ignored, and pend is cleared.

Decomposition:
- Shared package/define file holds:
  - ChipEnable/ChipDisable and RstEnable constants
  - the InstAddrBus width macro
  - BOOT/RUN state encodings
  - default RESET_VECTOR
- No sub-module is needed; pending-redirect register and next-pc mux live inline.
- Optional sub-module pc_next_mux (purely combinational priority select), reusable by a future dual-issue fetch.

Test Plan:
- Reset release: Rst=1 for 3 cycles, then 0 -> ce 0,0,0 then 1; pc sequence 0x0,0x0,0x0,0x0,0x4,0x8.
- Stall hold: stall=1 for 2 cycles at pc=0x10 -> pc stays 0x10 for those cycles, then 0x14.
- Branch under stall: stall=1, branch_flag pulse with target 0x100 -> pc holds and pend_valid=1; stall drops -> next pc=0x100, pend_valid=0, then 0x104.
- Flush vs. branch and stall: flush_pc=0x180, branch_target=0x200, flush=branch_flag=stall=1 -> pc=0x180, pend_valid=0.
- Wrap and alignment: with ADDR_W=32 and pc=0xFFFFFFFC -> pc=0x00000000. branch_target=0x1003 -> pc=0x1000.
- Reset mid-operation: Rst during a stall with pend_valid=1 -> pc=RESET_VECTOR, ce=0, pend_valid=0; no deferred redirect after release.
